// File: rtl/carrier_loop_ctrl_pkg.sv
// Shared types and constants for the carrier loop controller.
// Lock states, default widths/F0, and saturation bound helpers.
package carrier_loop_ctrl_pkg;

  typedef enum logic {
    ACQ    = 1'b0,
    LOCKED = 1'b1
  } lock_state_e;

  localparam int          DEF_EW  = 16;
  localparam int          DEF_APR = 32;
  localparam logic [31:0] DEF_F0  = 32'h0CCC_CCCD;

  // Loop values clamp to a quarter-range either side of zero
  // so the NCO never sees more than half its frequency span.
  function automatic longint sat_hi(input int w);
    return (longint'(1) <<< (w - 2)) - 1;
  endfunction

  function automatic longint sat_lo(input int w);
    return -(longint'(1) <<< (w - 2));
  endfunction

endpackage

// File: rtl/carrier_loop_ctrl_lock_det.sv
// Lock detector: counts consecutive in/out-of-threshold samples.
// Enters LOCKED after LOCK_N hits, drops after four misses.
module carrier_lock_det
  import carrier_loop_ctrl_pkg::*;
#(
  parameter int EW      = 16,
  parameter int LOCK_TH = 1024,
  parameter int LOCK_N  = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clken,
  input  logic          smp_i,
  input  logic [EW-2:0] abs_i,
  input  logic          clear_i,
  output logic          locked_o
);

  localparam int CW = $clog2(LOCK_N > 4 ? LOCK_N : 4);
  localparam logic [CW-1:0] ACQ_LAST = CW'(LOCK_N - 1);
  localparam logic [CW-1:0] LCK_LAST = CW'(3);
  localparam logic [EW:0]   TH1 = (EW+1)'(LOCK_TH);
  localparam logic [EW:0]   TH2 = (EW+1)'(2 * LOCK_TH);

  lock_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [EW:0]   abs_x;
  logic          hit;
  logic [CW-1:0] last;

  assign abs_x = {2'b00, abs_i};

  // Next-state: a "hit" is a sample that pushes toward leaving the state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hit     = 1'b0;
    last    = ACQ_LAST;
    unique case (state_q)
      ACQ: begin
        hit  = abs_x < TH1;
        last = ACQ_LAST;
      end
      LOCKED: begin
        hit  = abs_x >= TH2;
        last = LCK_LAST;
      end
      default: begin
        hit  = 1'b0;
        last = ACQ_LAST;
      end
    endcase
    if (clear_i) begin
      state_d = ACQ;
      cnt_d   = '0;
    end else if (smp_i) begin
      if (!hit) begin
        cnt_d = '0;
      end else if (cnt_q == last) begin
        state_d = (state_q == ACQ) ? LOCKED : ACQ;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // State and run counter, frozen while clken is low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ACQ;
      cnt_q   <= '0;
    end else if (clken) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign locked_o = (state_q == LOCKED);

endmodule

// File: rtl/carrier_loop_ctrl.sv
// PI carrier loop filter with centre-frequency register and lock detect.
// Two-stage pipeline: scale/abs, then integrate/sum with saturation.
module carrier_loop_ctrl
  import carrier_loop_ctrl_pkg::*;
#(
  parameter int              EW      = DEF_EW,
  parameter int              APR     = DEF_APR,
  parameter int              KP      = 12,
  parameter int              KI      = 4,
  parameter int              LOCK_TH = 1024,
  parameter int              LOCK_N  = 64,
  parameter logic [APR-1:0]  F0      = APR'(DEF_F0)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clken,
  input  logic signed [EW-1:0]  err_i,
  input  logic                  err_valid_i,
  input  logic                  hold_i,
  input  logic                  clear_i,
  input  logic                  cfg_we_i,
  input  logic [APR-1:0]        cfg_f0_i,
  output logic [APR-1:0]        phi_inc_o,
  output logic [APR-1:0]        freq_mod_o,
  output logic                  out_valid,
  output logic                  locked_o
);

  localparam int SW = APR + 1;
  localparam logic signed [APR:0] SAT_HI = SW'(sat_hi(APR));
  localparam logic signed [APR:0] SAT_LO = SW'(sat_lo(APR));

  function automatic logic signed [APR-1:0] sat(
    input logic signed [APR:0] x
  );
    logic signed [APR:0] y;
    if (x > SAT_HI)      y = SAT_HI;
    else if (x < SAT_LO) y = SAT_LO;
    else                 y = x;
    return y[APR-1:0];
  endfunction

  logic signed [APR-1:0] e_ext, p_new, i_new;
  logic signed [EW-1:0]  neg_e;
  logic [EW-2:0]         abs_new;

  logic                  s1_vld_q, s1_vld_d;
  logic signed [APR-1:0] s1_p_q, s1_p_d;
  logic signed [APR-1:0] s1_i_q, s1_i_d;
  logic [EW-2:0]         s1_abs_q, s1_abs_d;

  logic signed [APR-1:0] integ_q, integ_d;
  logic signed [APR-1:0] fm_q, fm_d;
  logic                  ov_q, ov_d;
  logic [APR-1:0]        phi_q, phi_d;

  logic signed [APR:0]   isum, fsum;
  logic signed [APR-1:0] integ_new;

  assign e_ext = APR'(err_i);
  assign p_new = e_ext <<< KP;
  assign i_new = e_ext <<< KI;
  assign neg_e = -err_i;

  // |err| with the most-negative code folded onto the largest positive.
  always_comb begin
    if (err_i[EW-1] && (err_i[EW-2:0] == '0))
      abs_new = '1;
    else if (err_i[EW-1])
      abs_new = neg_e[EW-2:0];
    else
      abs_new = err_i[EW-2:0];
  end

  // Stage 1: capture scaled paths and magnitude for an accepted sample.
  always_comb begin
    s1_vld_d = err_valid_i & ~clear_i;
    s1_p_d   = err_valid_i ? p_new   : s1_p_q;
    s1_i_d   = err_valid_i ? i_new   : s1_i_q;
    s1_abs_d = err_valid_i ? abs_new : s1_abs_q;
  end

  assign isum      = SW'(integ_q) + SW'(s1_i_q);
  assign integ_new = hold_i ? integ_q : sat(isum);
  assign fsum      = SW'(s1_p_q) + SW'(integ_new);

  // Stage 2: integrate and form the saturated correction.
  always_comb begin
    integ_d = integ_q;
    fm_d    = fm_q;
    ov_d    = 1'b0;
    if (clear_i) begin
      integ_d = '0;
      fm_d    = '0;
    end else if (s1_vld_q) begin
      integ_d = integ_new;
      fm_d    = sat(fsum);
      ov_d    = 1'b1;
    end
  end

  // Centre increment reload, unrelated to the loop pipeline.
  always_comb begin
    phi_d = cfg_we_i ? cfg_f0_i : phi_q;
  end

  // All datapath registers, gated by clken.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_vld_q <= 1'b0;
      s1_p_q   <= '0;
      s1_i_q   <= '0;
      s1_abs_q <= '0;
      integ_q  <= '0;
      fm_q     <= '0;
      ov_q     <= 1'b0;
      phi_q    <= F0;
    end else if (clken) begin
      s1_vld_q <= s1_vld_d;
      s1_p_q   <= s1_p_d;
      s1_i_q   <= s1_i_d;
      s1_abs_q <= s1_abs_d;
      integ_q  <= integ_d;
      fm_q     <= fm_d;
      ov_q     <= ov_d;
      phi_q    <= phi_d;
    end
  end

  carrier_lock_det #(
    .EW      (EW),
    .LOCK_TH (LOCK_TH),
    .LOCK_N  (LOCK_N)
  ) u_lock (
    .clk      (clk),
    .reset    (reset),
    .clken    (clken),
    .smp_i    (s1_vld_q),
    .abs_i    (s1_abs_q),
    .clear_i  (clear_i),
    .locked_o (locked_o)
  );

  assign phi_inc_o  = phi_q;
  assign freq_mod_o = fm_q;
  assign out_valid  = ov_q;

endmodule

// File: tb/tb_carrier_loop_ctrl.sv
// Bench for carrier_loop_ctrl: hand vectors, directed corners,
// and random traffic against an arithmetic reference model.
module tb_carrier_loop_ctrl;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               clken = 1'b1;
  logic signed [15:0] err_i = '0;
  logic               err_valid_i = 1'b0;
  logic               hold_i = 1'b0;
  logic               clear_i = 1'b0;
  logic               cfg_we_i = 1'b0;
  logic [31:0]        cfg_f0_i = '0;
  logic [31:0]        phi_inc_o;
  logic [31:0]        freq_mod_o;
  logic               out_valid;
  logic               locked_o;

  carrier_loop_ctrl #(
    .EW(16), .APR(32), .KP(12), .KI(4),
    .LOCK_TH(1024), .LOCK_N(64), .F0(32'h0CCC_CCCD)
  ) dut (
    .clk(clk), .reset(reset), .clken(clken),
    .err_i(err_i), .err_valid_i(err_valid_i),
    .hold_i(hold_i), .clear_i(clear_i),
    .cfg_we_i(cfg_we_i), .cfg_f0_i(cfg_f0_i),
    .phi_inc_o(phi_inc_o), .freq_mod_o(freq_mod_o),
    .out_valid(out_valid), .locked_o(locked_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  longint m_phi, m_integ, m_fm, m_pend_e;
  bit     m_pend, m_ov, m_lk;
  int     m_run;

  localparam longint HI = (longint'(1) <<< 30) - 1;
  localparam longint LO = -(longint'(1) <<< 30);

  task automatic chk(string nm, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", nm, act, exp);
    end
  endtask

  function automatic longint msat(longint x);
    if (x > HI) return HI;
    if (x < LO) return LO;
    return x;
  endfunction

  task automatic model_reset();
    m_phi = 64'h0CCC_CCCD;
    m_integ = 0; m_fm = 0; m_pend = 0; m_pend_e = 0;
    m_ov = 0; m_lk = 0; m_run = 0;
  endtask

  // One enabled clock edge, expressed in loop arithmetic.
  task automatic model_edge(bit v, longint e, bit h, bit c,
                            bit we, longint f0);
    longint a;
    if (we) m_phi = f0;
    if (c) begin
      m_integ = 0; m_fm = 0; m_pend = 0;
      m_ov = 0; m_lk = 0; m_run = 0;
      return;
    end
    m_ov = 0;
    if (m_pend) begin
      if (!h) m_integ = msat(m_integ + m_pend_e * 16);
      m_fm = msat(m_pend_e * 4096 + m_integ);
      m_ov = 1;
      a = (m_pend_e < 0) ? -m_pend_e : m_pend_e;
      if (a > 32767) a = 32767;
      if (!m_lk) begin
        m_run = (a < 1024) ? m_run + 1 : 0;
        if (m_run == 64) begin m_lk = 1; m_run = 0; end
      end else begin
        m_run = (a >= 2048) ? m_run + 1 : 0;
        if (m_run == 4) begin m_lk = 0; m_run = 0; end
      end
    end
    m_pend = v;
    m_pend_e = e;
  endtask

  task automatic compare_all();
    chk("out_valid", longint'(out_valid), longint'(m_ov));
    chk("freq_mod", longint'($signed(freq_mod_o)), m_fm);
    chk("locked", longint'(locked_o), longint'(m_lk));
    chk("phi_inc", longint'(phi_inc_o), m_phi);
  endtask

  task automatic step();
    bit v, h, c, we, en;
    longint e, f0;
    v = err_valid_i; h = hold_i; c = clear_i; we = cfg_we_i;
    en = clken; e = longint'(err_i); f0 = longint'(cfg_f0_i);
    @(posedge clk);
    if (en) model_edge(v, e, h, c, we, f0);
    #1;
    compare_all();
  endtask

  task automatic do_clear();
    clear_i = 1'b1;
    step();
    clear_i = 1'b0;
  endtask

  typedef struct {
    logic signed [15:0] e;
    bit                 h;
    longint             fm;
  } vec_t;

  vec_t tbl[6];

  initial begin
    tbl[0] = '{16'sd1,  1'b0, 64'sd4112};
    tbl[1] = '{16'sd1,  1'b0, 64'sd4128};
    tbl[2] = '{-16'sd1, 1'b0, -64'sd4080};
    tbl[3] = '{16'sd0,  1'b0, 64'sd16};
    tbl[4] = '{16'sd2,  1'b0, 64'sd8240};
    tbl[5] = '{16'sd1,  1'b1, 64'sd4144};

    // Reset state and idle behaviour
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_phi", longint'(phi_inc_o), 64'h0CCC_CCCD);
    chk("rst_fm", longint'(freq_mod_o), 0);
    chk("rst_ov", longint'(out_valid), 0);
    chk("rst_lk", longint'(locked_o), 0);
    reset = 1'b0;
    repeat (10) begin
      step();
      chk("idle_ov", longint'(out_valid), 0);
    end

    // Hand-computed PI vectors
    for (int i = 0; i < 6; i++) begin
      err_i = tbl[i].e;
      hold_i = tbl[i].h;
      err_valid_i = 1'b1;
      step();
      chk("tbl_ov_early", longint'(out_valid), 0);
      err_valid_i = 1'b0;
      step();
      hold_i = 1'b0;
      chk("tbl_ov", longint'(out_valid), 1);
      chk("tbl_fm", longint'($signed(freq_mod_o)), tbl[i].fm);
      step();
      chk("tbl_hold_fm", longint'($signed(freq_mod_o)), tbl[i].fm);
    end

    // Positive saturation and integrator hold
    do_clear();
    err_i = 16'sh7FFF;
    err_valid_i = 1'b1;
    repeat (2000) step();
    err_valid_i = 1'b0;
    repeat (2) step();
    chk("clamp_fm", longint'($signed(freq_mod_o)), 64'h3FFF_FFFF);
    hold_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      err_i = 16'sd0;
      err_valid_i = 1'b1;
      step();
      err_valid_i = 1'b0;
      step();
      chk("hold_fm", longint'($signed(freq_mod_o)), 64'd1048544000);
    end
    hold_i = 1'b0;
    err_i = 16'sh7FFF;
    err_valid_i = 1'b1;
    repeat (100) step();
    err_valid_i = 1'b0;
    step();
    chk("clamp_fm2", longint'($signed(freq_mod_o)), 64'h3FFF_FFFF);

    // Lock acquire, tolerated misses, and loss of lock
    do_clear();
    err_i = 16'sd100;
    err_valid_i = 1'b1;
    repeat (64) step();
    chk("lock_63", longint'(locked_o), 0);
    err_valid_i = 1'b0;
    step();
    chk("lock_64", longint'(locked_o), 1);
    begin
      int seq [8] = '{3000, 3000, 3000, 100, 3000, 3000, 3000, 3000};
      for (int k = 0; k < 8; k++) begin
        err_i = 16'(seq[k]);
        err_valid_i = 1'b1;
        step();
        if (k == 7) chk("lock_keep", longint'(locked_o), 1);
      end
      err_valid_i = 1'b0;
      step();
      chk("lock_lost", longint'(locked_o), 0);
    end

    // Clear racing an incoming sample, and a stage-1 sample
    err_i = 16'sd100;
    err_valid_i = 1'b1;
    repeat (64) step();
    err_valid_i = 1'b1;
    clear_i = 1'b1;
    step();
    clear_i = 1'b0;
    err_valid_i = 1'b0;
    step();
    chk("clr_ov", longint'(out_valid), 0);
    chk("clr_fm", longint'(freq_mod_o), 0);
    chk("clr_lk", longint'(locked_o), 0);
    err_i = 16'sd500;
    err_valid_i = 1'b1;
    step();
    err_valid_i = 1'b0;
    clear_i = 1'b1;
    step();
    clear_i = 1'b0;
    step();
    chk("clr1_ov", longint'(out_valid), 0);
    chk("clr1_fm", longint'(freq_mod_o), 0);

    // Clock-enable stall and centre-increment load
    err_i = 16'sd5;
    err_valid_i = 1'b1;
    step();
    err_valid_i = 1'b0;
    clken = 1'b0;
    cfg_we_i = 1'b1;
    cfg_f0_i = 32'h1000_0000;
    repeat (5) begin
      step();
      chk("stall_ov", longint'(out_valid), 0);
      chk("stall_phi", longint'(phi_inc_o), 64'h0CCC_CCCD);
    end
    clken = 1'b1;
    step();
    cfg_we_i = 1'b0;
    chk("stall_out", longint'(out_valid), 1);
    chk("stall_fm", longint'($signed(freq_mod_o)), 20480 + 80);
    chk("cfg_phi", longint'(phi_inc_o), 64'h1000_0000);

    // Reset in mid-flight drops the pending sample
    err_i = 16'sd7;
    err_valid_i = 1'b1;
    step();
    err_valid_i = 1'b0;
    #2 reset = 1'b1;
    model_reset();
    #1;
    chk("mid_rst_phi", longint'(phi_inc_o), 64'h0CCC_CCCD);
    @(negedge clk);
    reset = 1'b0;
    repeat (4) begin
      step();
      chk("mid_rst_ov", longint'(out_valid), 0);
    end

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      int r;
      r = int'($urandom_range(99));
      if (r < 85) err_i = 16'($urandom_range(1800) - 900);
      else if (r < 97) err_i = 16'($urandom_range(8000) - 4000);
      else err_i = 16'($urandom);
      err_valid_i = ($urandom_range(99) < 60);
      hold_i = ($urandom_range(99) < 10);
      clear_i = ($urandom_range(999) < 5);
      clken = ($urandom_range(99) < 88);
      cfg_we_i = ($urandom_range(99) < 3);
      cfg_f0_i = $urandom;
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/carrier_loop_ctrl.md
CARRIER_LOOP_CTRL -- requirements
Module: carrier_loop_ctrl

Interface
REQ-001 SHALL have parameter EW, default 16, phase-error sample width (signed).
REQ-002 SHALL have parameter APR, default 32, phase-increment / frequency-word width.
REQ-003 SHALL have parameter KP, default 12, proportional left-shift (0..APR-EW).
REQ-004 SHALL have parameter KI, default 4, integral left-shift (0..APR-EW).
REQ-005 SHALL have parameter LOCK_TH, default 1024, lock threshold on |err|, unsigned EW-1 bits.
REQ-006 SHALL have parameter LOCK_N, default 64, consecutive in-threshold samples needed to declare lock.
REQ-007 SHALL have parameter F0, default 32'h0CCC_CCCD, reset value of the centre phase increment.
REQ-008 clk  in  1  single clock; all state on its rising edge.
REQ-009 reset  in  1  asynchronous, active-high reset.
REQ-010 clken  in  1  clock enable; when low, no register changes state.
REQ-011 err_i  in  EW  signed phase-error sample.
REQ-012 err_valid_i  in  1  err_i qualifier, one-cycle strobe per sample.
REQ-013 hold_i  in  1  freeze the integrator (proportional path still active).
REQ-014 clear_i  in  1  synchronous integrator and lock-state clear.
REQ-015 cfg_we_i  in  1  load new centre increment.
REQ-016 cfg_f0_i  in  APR  new centre increment value.
REQ-017 phi_inc_o  out  APR  centre phase increment to the NCO phi_inc input.
REQ-018 freq_mod_o  out  APR  signed loop correction to the NCO freq_mod input.
REQ-019 out_valid  out  1  one-cycle strobe, freq_mod_o updated this cycle.
REQ-020 locked_o  out  1  lock indicator.

Function
REQ-021 Every sample: e = sign-extend(err_i) to APR; p = e<<<KP; i_inc = e<<<KI (arithmetic, no truncation).
REQ-022 Stage 1 (cycle after err_valid_i&clken) SHALL register p, i_inc and |err_i|; |most-negative| saturates to 2^(EW-1)-1.
REQ-023 Stage 2 SHALL update integ = sat(integ + i_inc) unless hold_i, and freq_mod_o = sat(p + integ_new); sat clamps to [-(2^(APR-2)), 2^(APR-2)-1].
REQ-024 out_valid SHALL assert exactly 2 enabled cycles after the accepted err_valid_i; back-to-back strobes each produce one out_valid.
REQ-025 Between strobes freq_mod_o SHALL hold its last value.
REQ-026 cfg_we_i SHALL load phi_inc_o next enabled cycle, independent of the loop pipeline.
REQ-027 clear_i SHALL zero integ, freq_mod_o, lock counter, locked_o, and discard in-flight samples (no out_valid for them); clear_i wins over simultaneous err_valid_i.
REQ-028 Lock FSM states: ACQ, LOCKED; reset and clear enter ACQ.
REQ-029 ACQ: per sample, |e|<LOCK_TH increments cnt, else cnt=0; cnt reaching LOCK_N-1 with an in-threshold sample -> LOCKED, cnt=0.
REQ-030 LOCKED: per sample, |e|>=2*LOCK_TH increments cnt, else cnt=0; cnt reaching 3 with an out-of-threshold sample -> ACQ, cnt=0 (four consecutive misses unlock).
REQ-031 locked_o SHALL be 1 iff state is LOCKED, updating in the same cycle as out_valid.
REQ-032 hold_i SHALL not affect the lock FSM.

Reset
REQ-033 On reset: phi_inc_o=F0, freq_mod_o=0, integ=0, out_valid=0, locked_o=0, state=ACQ, cnt=0, pipeline valids=0.
REQ-034 Reset asserted mid-operation SHALL drop in-flight samples; first out_valid after release requires a fresh err_valid_i.

Structure
REQ-035 Shared package SHALL hold lock state enum (ACQ, LOCKED), saturation bounds function, and default F0/width constants.
REQ-036 Lock FSM SHALL be a sub-module carrier_lock_det (inputs: sample strobe, |e|, clear; output locked).

Verification
REQ-037 Reset then idle: phi_inc_o=32'h0CCC_CCCD, freq_mod_o=0, out_valid never asserts.
REQ-038 err_i=16'sd1 strobe once: out_valid 2 cycles later, freq_mod_o=4096+16=4112; second strobe -> 4096+32=4128.
REQ-039 err_i=16'sh7FFF repeated with hold_i=0: freq_mod_o clamps at 32'h3FFF_FFFF and stays; with hold_i=1 integ unchanged.
REQ-040 64 strobes err_i=100 -> locked_o rises with 64th out_valid; then 4 strobes err_i=3000 -> locked_o falls with 4th; 3 misses then 1 hit keeps lock.
REQ-041 clear_i coincident with err_valid_i and with stage-1 sample: no out_valid, freq_mod_o=0, locked_o=0.
REQ-042 clken=0 for 5 cycles between err_valid_i and its output: out_valid appears after 2 enabled cycles; cfg_we_i with cfg_f0_i=32'h1000_0000 updates phi_inc_o next enabled cycle.
